fp_argmax_stream: RTL

//  Streaming arg-max stage downstream of the FP16 greater-than comparator (fp_comparator).

---
 rtl/fp_argmax_stream.sv | 99 +++++++++
 1 files changed

// File: rtl/fp_argmax_stream.sv
// fp_argmax_stream: streaming FP16 arg-max over valid/ready frames, one result beat per frame

// fp_comparator: gt = a > b for FP16 values, ordered as sign-magnitude bit fields
module fp_comparator (
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic        gt
);
  // Opposite signs: the non-negative one wins (so +0 > -0); equal signs compare magnitudes,
  // reversed for negatives. Bitwise-equal inputs are never greater.
  always_comb
    gt = (a[15] != b[15]) ? ~a[15] : (a[15] ? (a[14:0] < b[14:0]) : (a[14:0] > b[14:0]));
endmodule

module fp_argmax_stream #(
  parameter int DATA_WIDTH = 16,
  parameter int IDX_WIDTH  = 8,
  parameter int MAX_LEN    = 256
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [DATA_WIDTH-1:0] s_data,
  input  logic                  s_last,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_max,
  output logic [IDX_WIDTH-1:0]  m_idx,
  output logic [IDX_WIDTH-1:0]  m_count,
  output logic                  m_trunc
);
  typedef enum logic [1:0] {st_first, st_run, st_done} state_t;
  localparam logic [IDX_WIDTH-1:0] last_idx = IDX_WIDTH'(MAX_LEN - 1);
  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] max_q, max_d;
  logic [IDX_WIDTH-1:0]  idx_q, idx_d, cnt_q, cnt_d, cnt_nxt;
  logic                  trunc_q, trunc_d, gt, acc;
  fp_comparator u_cmp (
    .a (s_data),
    .b (max_q),
    .gt(gt)
  );
  assign s_ready = rst_n & (state_q != st_done);
  assign acc     = s_valid & s_ready;
  assign cnt_nxt = cnt_q + 1'b1;
  assign m_valid = state_q == st_done;
  assign m_max   = max_q;
  assign m_idx   = idx_q;
  assign m_count = cnt_q;
  assign m_trunc = trunc_q;
  // Next state: first beat seeds the running max, later beats update it on strict greater,
  // and the frame closes on s_last or when the element at index MAX_LEN-1 arrives.
  always_comb begin
    state_d = state_q;
    max_d   = max_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    trunc_d = trunc_q;
    case (state_q)
      st_first: if (acc) begin
        max_d   = s_data;
        idx_d   = '0;
        cnt_d   = '0;
        trunc_d = 1'b0;
        state_d = s_last ? st_done : st_run;
      end
      st_run: if (acc) begin
        cnt_d = cnt_nxt;
        if (gt) begin
          max_d = s_data;
          idx_d = cnt_nxt;
        end
        if (s_last || cnt_nxt == last_idx) begin
          state_d = st_done;
          trunc_d = ~s_last;
        end
      end
      st_done: if (m_ready) state_d = st_first;
      default: state_d = st_first;
    endcase
  end
  // State and frame registers; reset drops any partial frame or pending result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= st_first;
      max_q   <= '0;
      idx_q   <= '0;
      cnt_q   <= '0;
      trunc_q <= 1'b0;
    end else begin
      state_q <= state_d;
      max_q   <= max_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      trunc_q <= trunc_d;
    end
  end
endmodule
